// File: rtl/gpio_cfg_write_arbiter.sv
// gpio_cfg_write_arbiter
// ----------------------
// Arbitrates host/aux writes into the GPIO data-direction register file. Each
// granted write is shaped into a write_reg strobe that is exactly HoldCycles
// high, followed by at least GapCycles low. The downstream decoder is
// edge-triggered behind a two-stage synchroniser, so it must capture exactly one
// write per request. After every reset, every DDR register is first loaded with
// InitValue.
//
// Ports:
//   CLOCK       - sole clock
//   reset_reg   - synchronous active-high reset
//   h_req/h_addr/h_data - host request (held until h_ack), word address, data
//   h_ack/h_err - host one-cycle completion pulse / address-rejected flag
//   a_req/a_addr/a_data/a_ack/a_err - aux port, same behaviour as host
//   write_reg   - write strobe to the DDR decoder
//   busaddress  - word address to the decoder
//   busdata_in  - write data to the decoder
//   init_done   - high once default loading has completed
//   busy        - high in every state except IDLE
module gpio_cfg_write_arbiter #(
    parameter int                     AddrWidth    = 14,
    parameter int                     BusWidth     = 32,
    parameter int                     NumIOReg     = 6,
    parameter logic [AddrWidth-3:0]   BaseWordAddr = 12'h440,
    parameter logic [BusWidth-1:0]    InitValue    = {BusWidth{1'b0}},
    parameter int                     HoldCycles   = 3,
    parameter int                     GapCycles    = 3
) (
    input  logic                   CLOCK,
    input  logic                   reset_reg,
    input  logic                   h_req,
    input  logic [AddrWidth-3:0]   h_addr,
    input  logic [BusWidth-1:0]    h_data,
    output logic                   h_ack,
    output logic                   h_err,
    input  logic                   a_req,
    input  logic [AddrWidth-3:0]   a_addr,
    input  logic [BusWidth-1:0]    a_data,
    output logic                   a_ack,
    output logic                   a_err,
    output logic                   write_reg,
    output logic [AddrWidth-3:0]   busaddress,
    output logic [BusWidth-1:0]    busdata_in,
    output logic                   init_done,
    output logic                   busy
);

    localparam int WA     = AddrWidth - 2;
    localparam int CntMax = (HoldCycles > GapCycles) ? HoldCycles : GapCycles;
    localparam int CntW   = $clog2(CntMax + 1);
    localparam int IdxW   = (NumIOReg > 1) ? $clog2(NumIOReg) : 1;

    localparam logic [CntW-1:0] CntZero  = {CntW{1'b0}};
    localparam logic [CntW-1:0] CntOne   = CntW'(1);
    localparam logic [CntW-1:0] HoldLast = CntW'(HoldCycles);
    localparam logic [CntW-1:0] GapLast  = CntW'(GapCycles);
    localparam logic [IdxW-1:0] IdxZero  = {IdxW{1'b0}};
    localparam logic [IdxW-1:0] IdxOne   = IdxW'(1);
    localparam logic [IdxW-1:0] IdxLast  = IdxW'(NumIOReg - 1);
    localparam logic [WA-1:0]   LastWordAddr = BaseWordAddr + WA'(NumIOReg - 1);

    typedef enum logic [2:0] {
        INIT_HOLD = 3'd0,
        INIT_GAP  = 3'd1,
        IDLE      = 3'd2,
        HOLD      = 3'd3,
        GAP       = 3'd4,
        ACK       = 3'd5
    } state_t;

    state_t            state_r;
    logic [CntW-1:0]   cnt_r;        // cycles already spent in the current HOLD/GAP phase
    logic [IdxW-1:0]   idx_r;        // DDR register being initialised
    logic              last_aux_r;   // 1: aux was served last
    logic              grant_aux_r;  // port owning the write in flight

    logic              grant_any_s;
    logic              grant_aux_s;
    logic [WA-1:0]     sel_addr_s;
    logic [BusWidth-1:0] sel_data_s;
    logic              sel_in_range_s;

    function automatic logic addr_in_range(input logic [WA-1:0] addr);
        return (addr >= BaseWordAddr) && (addr <= LastWordAddr);
    endfunction

    // Round-robin grant decode: a lone requester wins, on contention the port not served last wins.
    always_comb begin
        grant_any_s = h_req | a_req;
        if (h_req && a_req) begin
            grant_aux_s = ~last_aux_r;
        end else if (a_req) begin
            grant_aux_s = 1'b1;
        end else begin
            grant_aux_s = 1'b0;
        end
        if (grant_aux_s) begin
            sel_addr_s = a_addr;
            sel_data_s = a_data;
        end else begin
            sel_addr_s = h_addr;
            sel_data_s = h_data;
        end
        sel_in_range_s = addr_in_range(sel_addr_s);
    end

    // Sequencer: init loading, grant, strobe shaping and ack generation; all outputs registered.
    always_ff @(posedge CLOCK) begin
        if (reset_reg) begin
            state_r     <= INIT_HOLD;
            cnt_r       <= CntZero;
            idx_r       <= IdxZero;
            last_aux_r  <= 1'b1;
            grant_aux_r <= 1'b0;
            write_reg   <= 1'b0;
            busaddress  <= {WA{1'b0}};
            busdata_in  <= {BusWidth{1'b0}};
            h_ack       <= 1'b0;
            h_err       <= 1'b0;
            a_ack       <= 1'b0;
            a_err       <= 1'b0;
            init_done   <= 1'b0;
            busy        <= 1'b1;
        end else begin
            h_ack <= 1'b0;
            h_err <= 1'b0;
            a_ack <= 1'b0;
            a_err <= 1'b0;
            case (state_r)
                INIT_HOLD: begin
                    // cnt_r == 0 only right after reset: the first strobe has not been launched yet.
                    if (cnt_r == CntZero) begin
                        write_reg  <= 1'b1;
                        busaddress <= BaseWordAddr + WA'(idx_r);
                        busdata_in <= InitValue;
                        cnt_r      <= CntOne;
                    end else if (cnt_r == HoldLast) begin
                        write_reg <= 1'b0;
                        cnt_r     <= CntOne;
                        state_r   <= INIT_GAP;
                    end else begin
                        cnt_r <= cnt_r + CntOne;
                    end
                end
                INIT_GAP: begin
                    if (cnt_r == GapLast) begin
                        if (idx_r == IdxLast) begin
                            init_done <= 1'b1;
                            busy      <= 1'b0;
                            cnt_r     <= CntZero;
                            state_r   <= IDLE;
                        end else begin
                            // Launch the next init strobe directly so the gap stays exactly GapCycles.
                            idx_r      <= idx_r + IdxOne;
                            write_reg  <= 1'b1;
                            busaddress <= BaseWordAddr + WA'(idx_r + IdxOne);
                            busdata_in <= InitValue;
                            cnt_r      <= CntOne;
                            state_r    <= INIT_HOLD;
                        end
                    end else begin
                        cnt_r <= cnt_r + CntOne;
                    end
                end
                IDLE: begin
                    if (grant_any_s) begin
                        last_aux_r  <= grant_aux_s;
                        grant_aux_r <= grant_aux_s;
                        busy        <= 1'b1;
                        if (sel_in_range_s) begin
                            write_reg  <= 1'b1;
                            busaddress <= sel_addr_s;
                            busdata_in <= sel_data_s;
                            cnt_r      <= CntOne;
                            state_r    <= HOLD;
                        end else begin
                            // Rejected: no strobe, complete with error on the next cycle.
                            h_ack   <= ~grant_aux_s;
                            h_err   <= ~grant_aux_s;
                            a_ack   <= grant_aux_s;
                            a_err   <= grant_aux_s;
                            state_r <= ACK;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                HOLD: begin
                    if (cnt_r == HoldLast) begin
                        write_reg <= 1'b0;
                        cnt_r     <= CntOne;
                        state_r   <= GAP;
                    end else begin
                        cnt_r <= cnt_r + CntOne;
                    end
                end
                GAP: begin
                    if (cnt_r == GapLast) begin
                        h_ack   <= ~grant_aux_r;
                        a_ack   <= grant_aux_r;
                        cnt_r   <= CntZero;
                        state_r <= ACK;
                    end else begin
                        cnt_r <= cnt_r + CntOne;
                    end
                end
                ACK: begin
                    // Always pass through IDLE so a just-acked request is never re-granted.
                    busy    <= 1'b0;
                    cnt_r   <= CntZero;
                    state_r <= IDLE;
                end
                default: begin
                    // Unreachable encoding: restart the init sequence from a known state.
                    state_r   <= INIT_HOLD;
                    cnt_r     <= CntZero;
                    idx_r     <= IdxZero;
                    write_reg <= 1'b0;
                    init_done <= 1'b0;
                    busy      <= 1'b1;
                end
            endcase
        end
    end

endmodule
